// File: rtl/nasti_lite_read_arbiter.sv
// N-master NASTI-lite read arbiter: round-robin AR grant into a one-entry slice,
// R beats routed back through a grant-index FIFO. Define NASTI_LITE_ARB_FIXED_PRIO_EN for fixed priority.

module nasti_lite_read_arbiter_lane #(
  parameter int IW   = 1,
  parameter int LANE = 0
) (
  input  logic          gnt_any,
  input  logic [IW-1:0] gnt_idx,
  input  logic          r_route,
  input  logic [IW-1:0] head,
  output logic          ar_ready,
  output logic          r_valid
);
  assign ar_ready = gnt_any && (gnt_idx == IW'(LANE));
  assign r_valid  = r_route && (head == IW'(LANE));
endmodule

module nasti_lite_read_arbiter #(
  parameter int N_MASTER        = 2,
  parameter int ID_WIDTH        = 1,
  parameter int ADDR_WIDTH      = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int USER_WIDTH      = 1,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [N_MASTER-1:0][ID_WIDTH-1:0]   m_ar_id,
  input  logic [N_MASTER-1:0][ADDR_WIDTH-1:0] m_ar_addr,
  input  logic [N_MASTER-1:0][2:0]            m_ar_prot,
  input  logic [N_MASTER-1:0][USER_WIDTH-1:0] m_ar_user,
  input  logic [N_MASTER-1:0]                 m_ar_valid,
  output logic [N_MASTER-1:0]                 m_ar_ready,
  output logic [ID_WIDTH-1:0]                 m_r_id,
  output logic [DATA_WIDTH-1:0]               m_r_data,
  output logic [1:0]                          m_r_resp,
  output logic [USER_WIDTH-1:0]               m_r_user,
  output logic [N_MASTER-1:0]                 m_r_valid,
  input  logic [N_MASTER-1:0]                 m_r_ready,
  output logic [ID_WIDTH-1:0]                 s_ar_id,
  output logic [ADDR_WIDTH-1:0]               s_ar_addr,
  output logic [2:0]                          s_ar_prot,
  output logic [USER_WIDTH-1:0]               s_ar_user,
  output logic                                s_ar_valid,
  input  logic                                s_ar_ready,
  input  logic [ID_WIDTH-1:0]                 s_r_id,
  input  logic [DATA_WIDTH-1:0]               s_r_data,
  input  logic [1:0]                          s_r_resp,
  input  logic [USER_WIDTH-1:0]               s_r_user,
  input  logic                                s_r_valid,
  output logic                                s_r_ready
);
  localparam int IW = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_dw
    $fatal(1, "nasti_lite_read_arbiter: DATA_WIDTH must be 32 or 64");
  end

  logic                          slice_free, fifo_ok, gnt_any, pop, r_route;
  logic [IW-1:0]                 gnt_idx, head;
  logic [MAX_OUTSTANDING-1:0][IW-1:0] route_q;
  logic [PW-1:0]                 wr_ptr, rd_ptr;
  logic [CW-1:0]                 cnt;

  assign slice_free = !s_ar_valid || s_ar_ready;
  // A pop in this cycle does not free a slot until the next one.
  assign fifo_ok    = cnt < CW'(MAX_OUTSTANDING);

`ifdef NASTI_LITE_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (slice_free && fifo_ok)
      for (int i = N_MASTER - 1; i >= 0; i--)
        if (m_ar_valid[i]) begin
          gnt_any = 1'b1;
          gnt_idx = IW'(i);
        end
  end
`else
  logic [IW-1:0] rr_last;

  // Scan backwards so the last hit is the first master after rr_last.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (slice_free && fifo_ok)
      for (int i = N_MASTER; i >= 1; i--)
        if (m_ar_valid[IW'((int'(rr_last) + i) % N_MASTER)]) begin
          gnt_any = 1'b1;
          gnt_idx = IW'((int'(rr_last) + i) % N_MASTER);
        end
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn)        rr_last <= IW'(N_MASTER - 1);
    else if (gnt_any) rr_last <= gnt_idx;
`endif

  assign head    = route_q[rd_ptr];
  assign r_route = s_r_valid && (cnt != '0);
  assign pop     = s_r_valid && s_r_ready;

  for (genvar k = 0; k < N_MASTER; k++) begin : g_lane
    nasti_lite_read_arbiter_lane #(.IW(IW), .LANE(k)) u_lane (
      .gnt_any  (gnt_any),
      .gnt_idx  (gnt_idx),
      .r_route  (r_route),
      .head     (head),
      .ar_ready (m_ar_ready[k]),
      .r_valid  (m_r_valid[k])
    );
  end

  assign s_r_ready = (cnt != '0) && m_r_ready[head];
  assign m_r_id    = s_r_id;
  assign m_r_data  = s_r_data;
  assign m_r_resp  = s_r_resp;
  assign m_r_user  = s_r_user;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      s_ar_valid <= 1'b0;
      s_ar_id    <= '0;
      s_ar_addr  <= '0;
      s_ar_prot  <= '0;
      s_ar_user  <= '0;
    end else if (gnt_any) begin
      s_ar_valid <= 1'b1;
      s_ar_id    <= m_ar_id[gnt_idx];
      s_ar_addr  <= m_ar_addr[gnt_idx];
      s_ar_prot  <= m_ar_prot[gnt_idx];
      s_ar_user  <= m_ar_user[gnt_idx];
    end else if (s_ar_ready) begin
      s_ar_valid <= 1'b0;
    end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      route_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
    end else begin
      if (gnt_any) begin
        route_q[wr_ptr] <= gnt_idx;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (gnt_any && !pop)      cnt <= cnt + CW'(1);
      else if (!gnt_any && pop) cnt <= cnt - CW'(1);
    end

`ifndef SYNTHESIS
  // A beat with nothing outstanding means the slave is misbehaving.
  a_no_orphan_r: assert property (@(posedge clk) disable iff (!rstn)
    !(s_r_valid && cnt == '0))
    else $error("nasti_lite_read_arbiter: slave R beat with no outstanding AR");
`endif

endmodule

// File: tb/tb_nasti_lite_read_arbiter.sv
// Scoreboard bench for nasti_lite_read_arbiter: random masters/slave against a queue-based model.

module tb_nasti_lite_read_arbiter;
  localparam int N    = 2;
  localparam int IDW  = 1;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int UW   = 1;
  localparam int MAXO = 4;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [AW-1:0]  addr;
    logic [2:0]     prot;
    logic [UW-1:0]  user;
  } req_t;

  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0][IDW-1:0] m_ar_id;
  logic [N-1:0][AW-1:0]  m_ar_addr;
  logic [N-1:0][2:0]     m_ar_prot;
  logic [N-1:0][UW-1:0]  m_ar_user;
  logic [N-1:0]          m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
  logic [IDW-1:0]        m_r_id, s_ar_id, s_r_id;
  logic [DW-1:0]         m_r_data, s_r_data;
  logic [1:0]            m_r_resp, s_r_resp;
  logic [UW-1:0]         m_r_user, s_ar_user, s_r_user;
  logic [AW-1:0]         s_ar_addr;
  logic [2:0]            s_ar_prot;
  logic                  s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;

  nasti_lite_read_arbiter #(.N_MASTER(N), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                            .USER_WIDTH(UW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rstn(rstn),
    .m_ar_id(m_ar_id), .m_ar_addr(m_ar_addr), .m_ar_prot(m_ar_prot), .m_ar_user(m_ar_user),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_r_id(m_r_id), .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_user(m_r_user),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
    .s_ar_id(s_ar_id), .s_ar_addr(s_ar_addr), .s_ar_prot(s_ar_prot), .s_ar_user(s_ar_user),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
    .s_r_id(s_r_id), .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_user(s_r_user),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready));

  int checks = 0, errors = 0;
  int issue_pct = 100, sar_pct = 100, rv_pct = 100;
  int rr_pct[N];

  req_t mq[N][$];       // requests each master still has to issue
  req_t expr[N][$];     // scoreboard: beats each master is owed, in order
  req_t slv_q[$];       // slave's accepted, unanswered ARs
  int   route[$];       // model of the outstanding issuers
  int   dlog[$];        // DUT grant order
  bit   mdl_sv;
  req_t mdl_slice;
  int   mdl_rr;
  logic [N-1:0] hs_m;
  bit   r_pop;
  int   acc_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rdata(input req_t r);
    return {r.addr, ~r.addr, 5'(r.prot), 2'(r.id), 1'(r.user), 8'hA5};
  endfunction

  function automatic bit bit_at(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  // Monitor, reference model and slave-side sampling, all away from the active edge.
  always @(negedge clk) begin
    int eg;
    logic [N-1:0] er, ev;
    bit esr;
    req_t r;
    if (!rstn) begin
      mdl_sv = 1'b0; mdl_rr = N - 1; route.delete(); slv_q.delete();
      hs_m = '0; r_pop = 1'b0;
    end else begin
      eg = -1;
      if ((!mdl_sv || s_ar_ready) && route.size() < MAXO) begin
`ifdef NASTI_LITE_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++)
          if (eg < 0 && bit_at(m_ar_valid, i)) eg = i;
`else
        for (int i = 1; i <= N; i++)
          if (eg < 0 && bit_at(m_ar_valid, (mdl_rr + i) % N)) eg = (mdl_rr + i) % N;
`endif
      end
      er = (eg >= 0) ? (N'(1) << eg) : '0;
      chk("m_ar_ready", 64'(m_ar_ready), 64'(er));
      chk("s_ar_valid", 64'(s_ar_valid), 64'(mdl_sv));
      if (mdl_sv) chk("s_ar_fields", 64'({s_ar_id, s_ar_addr, s_ar_prot, s_ar_user}), 64'(mdl_slice));
      ev = '0; esr = 1'b0;
      if (route.size() > 0) begin
        ev  = s_r_valid ? (N'(1) << route[0]) : '0;
        esr = bit_at(m_r_ready, route[0]);
      end
      chk("m_r_valid", 64'(m_r_valid), 64'(ev));
      chk("s_r_ready", 64'(s_r_ready), 64'(esr));
      for (int k = 0; k < N; k++)
        if (m_r_valid[k] && m_r_ready[k]) begin
          if (expr[k].size() == 0) begin
            checks++; errors++;
            $display("FAIL r_unexpected master=%0d actual=beat expected=none t=%0t", k, $time);
          end else begin
            r = expr[k].pop_front();
            chk("r_beat", 64'({m_r_id, m_r_data, m_r_resp, m_r_user}),
                64'({r.id, rdata(r), r.addr[1:0], r.addr[2]}));
          end
        end
      hs_m = m_ar_valid & m_ar_ready;
      for (int k = 0; k < N; k++) if (hs_m[k]) begin acc_cnt++; dlog.push_back(k); end
      r_pop = s_r_valid && s_r_ready;
      if (s_ar_valid && s_ar_ready) slv_q.push_back({s_ar_id, s_ar_addr, s_ar_prot, s_ar_user});
      if (r_pop && slv_q.size() > 0) void'(slv_q.pop_front());
      // model state advance
      if (route.size() > 0 && s_r_valid && bit_at(m_r_ready, route[0])) void'(route.pop_front());
      if (eg >= 0) begin
        mdl_slice = mq[eg][0]; mdl_sv = 1'b1; mdl_rr = eg;
        route.push_back(eg); expr[eg].push_back(mq[eg][0]);
      end else if (s_ar_ready) mdl_sv = 1'b0;
    end
  end

  // Master and slave drivers.
  initial begin
    logic [N-1:0] mv;
    bit sv;
    mv = '0; sv = 1'b0;
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        if (hs_m[k]) begin void'(mq[k].pop_front()); mv[k] = 1'b0; end
        if (!mv[k] && mq[k].size() > 0 && $urandom_range(99) < issue_pct) mv[k] = 1'b1;
        if (mq[k].size() > 0) begin
          m_ar_id[k] = mq[k][0].id;     m_ar_addr[k] = mq[k][0].addr;
          m_ar_prot[k] = mq[k][0].prot; m_ar_user[k] = mq[k][0].user;
        end
        m_r_ready[k] = ($urandom_range(99) < rr_pct[k]);
      end
      m_ar_valid = mv;
      s_ar_ready = ($urandom_range(99) < sar_pct);
      if (r_pop) sv = 1'b0;
      if (!sv && slv_q.size() > 0 && $urandom_range(99) < rv_pct) sv = 1'b1;
      s_r_valid = sv;
      if (sv) begin
        s_r_id = slv_q[0].id; s_r_data = rdata(slv_q[0]);
        s_r_resp = slv_q[0].addr[1:0]; s_r_user = slv_q[0].addr[2];
      end
    end
  end

  task automatic push_req(input int k, input logic [AW-1:0] a);
    req_t r;
    r.id = IDW'($urandom); r.addr = a; r.prot = 3'($urandom); r.user = UW'($urandom);
    mq[k].push_back(r);
  endtask

  function automatic bit idle();
    bit b;
    b = !mdl_sv && !s_ar_valid && route.size() == 0 && slv_q.size() == 0 && m_ar_valid == '0;
    for (int k = 0; k < N; k++) b = b && mq[k].size() == 0 && expr[k].size() == 0;
    return b;
  endfunction

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(negedge clk);
      ok = idle();
    end
    chk(nm, 64'(ok), 64'd1);
  endtask

  task automatic all_ready();
    issue_pct = 100; sar_pct = 100; rv_pct = 100;
    for (int k = 0; k < N; k++) rr_pct[k] = 100;
  endtask

  initial begin
    int a0, d0;
    bit seen;
    int exp_ord[4];
    m_ar_valid = '0; m_ar_id = '0; m_ar_addr = '0; m_ar_prot = '0; m_ar_user = '0;
    m_r_ready = '0; s_ar_ready = 1'b0; s_r_valid = 1'b0;
    s_r_id = '0; s_r_data = '0; s_r_resp = '0; s_r_user = '0;
    all_ready();

    // reset state, then idle
    repeat (3) @(negedge clk);
    chk("rst_s_ar_valid", 64'(s_ar_valid), 64'd0);
    chk("rst_m_ar_ready", 64'(m_ar_ready), 64'd0);
    chk("rst_m_r_valid", 64'(m_r_valid), 64'd0);
    chk("rst_s_r_ready", 64'(s_r_ready), 64'd0);
    rstn = 1'b1;
    repeat (10) @(negedge clk);

    // both masters continuously valid
    dlog.delete();
    for (int i = 0; i < 4; i++) begin push_req(0, AW'(8'h10 + i)); push_req(1, AW'(8'h20 + i)); end
    wait_idle("idle_rr");
`ifdef NASTI_LITE_ARB_FIXED_PRIO_EN
    exp_ord = '{0, 0, 0, 0};
`else
    exp_ord = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < 4; i++) chk("grant_order", 64'(dlog.size() > i ? dlog[i] : -1), 64'(exp_ord[i]));

    // route FIFO full: 5 ARs from master 1, no responses
    rv_pct = 0; a0 = acc_cnt;
    for (int i = 0; i < 5; i++) push_req(1, AW'(8'h30 + i));
    repeat (12) @(negedge clk);
    chk("full_accepted", 64'(acc_cnt - a0), 64'd4);
    chk("full_ar_ready", 64'(m_ar_ready), 64'd0);
    rv_pct = 100;
    wait_idle("idle_full");
    chk("full_total", 64'(acc_cnt - a0), 64'd5);

    // slave AR backpressure with 0x40 held in the slice
    sar_pct = 0; a0 = acc_cnt;
    push_req(0, 8'h40);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin @(negedge clk); seen = s_ar_valid; end
    chk("hold_seen", 64'(seen), 64'd1);
    push_req(1, 8'h44);
    repeat (3) begin
      @(negedge clk);
      chk("hold_addr", 64'(s_ar_addr), 64'h40);
    end
    sar_pct = 100;
    wait_idle("idle_hold");
    chk("hold_no_dup", 64'(acc_cnt - a0), 64'd2);

    // R backpressure from master 0 blocks master 1's later beat
    rr_pct[0] = 0;
    push_req(0, 8'hDE); push_req(1, 8'hAD);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin @(negedge clk); seen = m_r_valid[0]; end
    chk("rblk_seen", 64'(seen), 64'd1);
    repeat (2) begin
      chk("rblk_s_r_ready", 64'(s_r_ready), 64'd0);
      chk("rblk_m1_valid", 64'(m_r_valid[1]), 64'd0);
      @(negedge clk);
    end
    rr_pct[0] = 100;
    wait_idle("idle_rblk");

    // random traffic
    d0 = dlog.size();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c % 100 == 0) begin
        issue_pct = $urandom_range(100, 20); sar_pct = $urandom_range(100, 20);
        rv_pct = $urandom_range(100, 20);
        for (int k = 0; k < N; k++) rr_pct[k] = $urandom_range(100, 20);
      end
      if ($urandom_range(99) < 30) push_req($urandom_range(N - 1), AW'($urandom));
    end
    all_ready();
    wait_idle("idle_random");
    chk("random_progress", 64'(dlog.size() > d0 + 100), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
